// File: rtl/mt_pkg.sv
// +----------------------------------------------------------------------------+
// | mt_pkg: shared defaults, width helper and checkpoint-entry type for mt_ckpt |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mt_pkg;

    localparam int c_disp_w_def = 2;
    localparam int c_cdb_w_def  = 6;
    localparam int c_num_ar_def = 32;
    localparam int c_num_pr_def = 64;
    localparam int c_ckpt_n_def = 4;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int c_ar_w_def = width_of(c_num_ar_def);
    localparam int c_pr_w_def = width_of(c_num_pr_def);
    localparam int c_ck_w_def = width_of(c_ckpt_n_def);

    // Sized from the package defaults; NUM_AR/NUM_PR overrides must match them.
    typedef struct packed {
        logic [c_num_ar_def-1:0][c_pr_w_def-1:0] map;
        logic [c_num_ar_def-1:0]                 ready;
        logic                                    valid;
        logic                                    done;
    } ckpt_entry_t;

endpackage

`default_nettype wire

// File: rtl/mt_ckpt_if.sv
// +----------------------------------------------------------------------------+
// | mt_ckpt_if: dispatch, rename, CDB and branch-resolution bus of mt_ckpt     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mt_ckpt_if
    import mt_pkg::*;
#(
    parameter int DISP_W = c_disp_w_def,
    parameter int CDB_W  = c_cdb_w_def,
    parameter int NUM_AR = c_num_ar_def,
    parameter int NUM_PR = c_num_pr_def,
    parameter int CKPT_N = c_ckpt_n_def
);
    localparam int AR_W = width_of(NUM_AR);
    localparam int PR_W = width_of(NUM_PR);
    localparam int CK_W = width_of(CKPT_N);

    logic [DISP_W-1:0]      disp_valid;
    logic [DISP_W-1:0]      disp_wr;
    logic [DISP_W*AR_W-1:0] disp_dest;
    logic [DISP_W*PR_W-1:0] disp_pr;
    logic [DISP_W*AR_W-1:0] disp_src_a;
    logic [DISP_W*AR_W-1:0] disp_src_b;
    logic [DISP_W-1:0]      disp_ckpt;
    logic [DISP_W*PR_W-1:0] src_a_pr;
    logic [DISP_W*PR_W-1:0] src_b_pr;
    logic [DISP_W-1:0]      src_a_rdy;
    logic [DISP_W-1:0]      src_b_rdy;
    logic [DISP_W*PR_W-1:0] told;
    logic [DISP_W*CK_W-1:0] ckpt_id;
    logic [CK_W:0]          ckpt_free;
    logic                   ckpt_ovf;
    logic [CDB_W-1:0]       cdb_valid;
    logic [CDB_W*PR_W-1:0]  cdb_pr;
    logic [CDB_W*AR_W-1:0]  cdb_ar;
    logic                   br_valid;
    logic [CK_W-1:0]        br_id;
    logic                   br_mispred;

    modport master (
        output disp_valid, disp_wr, disp_dest, disp_pr, disp_src_a, disp_src_b, disp_ckpt,
        output cdb_valid, cdb_pr, cdb_ar, br_valid, br_id, br_mispred,
        input  src_a_pr, src_b_pr, src_a_rdy, src_b_rdy, told, ckpt_id, ckpt_free, ckpt_ovf
    );

    modport slave (
        input  disp_valid, disp_wr, disp_dest, disp_pr, disp_src_a, disp_src_b, disp_ckpt,
        input  cdb_valid, cdb_pr, cdb_ar, br_valid, br_id, br_mispred,
        output src_a_pr, src_b_pr, src_a_rdy, src_b_rdy, told, ckpt_id, ckpt_free, ckpt_ovf
    );

endinterface

`default_nettype wire

// File: rtl/mt_group_fwd.sv
// +----------------------------------------------------------------------------+
// | mt_group_fwd: source renaming and told lookup with in-group forwarding     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mt_group_fwd #(
    parameter int DISP_W = 2,
    parameter int NUM_AR = 32,
    parameter int AR_W   = 5,
    parameter int PR_W   = 6
) (
    input  wire logic [DISP_W-1:0]             i_disp_valid,
    input  wire logic [DISP_W-1:0]             i_disp_wr,
    input  wire logic [DISP_W*AR_W-1:0]        i_disp_dest,
    input  wire logic [DISP_W*PR_W-1:0]        i_disp_pr,
    input  wire logic [DISP_W*AR_W-1:0]        i_src_a,
    input  wire logic [DISP_W*AR_W-1:0]        i_src_b,
    input  wire logic [NUM_AR-1:0][PR_W-1:0]   i_map,
    input  wire logic [NUM_AR-1:0]             i_ready,
    output logic      [DISP_W*PR_W-1:0]        o_src_a_pr,
    output logic      [DISP_W*PR_W-1:0]        o_src_b_pr,
    output logic      [DISP_W-1:0]             o_src_a_rdy,
    output logic      [DISP_W-1:0]             o_src_b_rdy,
    output logic      [DISP_W*PR_W-1:0]        o_told
);

    logic [AR_W-1:0] w_sa, w_sb, w_dst, w_dj;
    logic [PR_W-1:0] w_pa, w_pb, w_pt, w_pj;
    logic            w_ra, w_rb;

    always_comb begin
        o_src_a_pr  = '0;
        o_src_b_pr  = '0;
        o_src_a_rdy = '0;
        o_src_b_rdy = '0;
        o_told      = '0;
        w_sa = '0; w_sb = '0; w_dst = '0; w_dj = '0;
        w_pa = '0; w_pb = '0; w_pt = '0; w_pj = '0;
        w_ra = 1'b0; w_rb = 1'b0;
        for (int i = 0; i < DISP_W; i++) begin
            w_sa  = i_src_a[i*AR_W +: AR_W];
            w_sb  = i_src_b[i*AR_W +: AR_W];
            w_dst = i_disp_dest[i*AR_W +: AR_W];
            w_pa  = i_map[w_sa];
            w_ra  = i_ready[w_sa];
            w_pb  = i_map[w_sb];
            w_rb  = i_ready[w_sb];
            w_pt  = i_map[w_dst];
            // Later j overrides earlier, so the youngest earlier writer wins.
            for (int j = 0; j < i; j++) begin
                w_dj = i_disp_dest[j*AR_W +: AR_W];
                w_pj = i_disp_pr[j*PR_W +: PR_W];
                if (i_disp_valid[j] && i_disp_wr[j]) begin
                    if (w_dj == w_sa) begin
                        w_pa = w_pj;
                        w_ra = 1'b0;
                    end
                    if (w_dj == w_sb) begin
                        w_pb = w_pj;
                        w_rb = 1'b0;
                    end
                    if (w_dj == w_dst) begin
                        w_pt = w_pj;
                    end
                end
            end
            o_src_a_pr[i*PR_W +: PR_W] = w_pa;
            o_src_b_pr[i*PR_W +: PR_W] = w_pb;
            o_src_a_rdy[i]             = w_ra;
            o_src_b_rdy[i]             = w_rb;
            o_told[i*PR_W +: PR_W]     = w_pt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mt_ckpt.sv
// +----------------------------------------------------------------------------+
// | mt_ckpt: rename map + ready table with circular branch-checkpoint queue    |
// | Optional: MT_PERF_CNT_EN adds renames_cnt / restores_cnt counters          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mt_ckpt
    import mt_pkg::*;
#(
    parameter int DISP_W = c_disp_w_def,
    parameter int CDB_W  = c_cdb_w_def,
    parameter int NUM_AR = c_num_ar_def,
    parameter int NUM_PR = c_num_pr_def,
    parameter int CKPT_N = c_ckpt_n_def
) (
    input  wire logic  clock,
    input  wire logic  reset,
    mt_ckpt_if.slave   bus
`ifdef MT_PERF_CNT_EN
    ,
    output logic [31:0] renames_cnt,
    output logic [31:0] restores_cnt
`endif
);

    localparam int AR_W  = width_of(NUM_AR);
    localparam int PR_W  = width_of(NUM_PR);
    localparam int CK_W  = width_of(CKPT_N);
    localparam int CNT_W = 8;

    logic [NUM_AR-1:0][PR_W-1:0] r_map, w_map;
    logic [NUM_AR-1:0]           r_ready, w_ready;
    ckpt_entry_t                 r_ck [CKPT_N];
    ckpt_entry_t                 w_ck [CKPT_N];
    logic [CK_W-1:0]             r_head, r_tail, w_head, w_tail;
    logic [CK_W:0]               r_count, w_count, w_free;
    logic                        r_ovf, w_ovf;

    logic [CNT_W-1:0] w_need;
    logic             w_mis, w_res, w_grp_ovf, w_acc, w_stop;
    logic [CK_W-1:0]  w_slot, w_idx, w_off, w_id_slot;
    logic [AR_W-1:0]  w_ar;
    logic [PR_W-1:0]  w_pr;

    mt_group_fwd #(
        .DISP_W (DISP_W),
        .NUM_AR (NUM_AR),
        .AR_W   (AR_W),
        .PR_W   (PR_W)
    ) u_group_fwd (
        .i_disp_valid (bus.disp_valid),
        .i_disp_wr    (bus.disp_wr),
        .i_disp_dest  (bus.disp_dest),
        .i_disp_pr    (bus.disp_pr),
        .i_src_a      (bus.disp_src_a),
        .i_src_b      (bus.disp_src_b),
        .i_map        (r_map),
        .i_ready      (r_ready),
        .o_src_a_pr   (bus.src_a_pr),
        .o_src_b_pr   (bus.src_b_pr),
        .o_src_a_rdy  (bus.src_a_rdy),
        .o_src_b_rdy  (bus.src_b_rdy),
        .o_told       (bus.told)
    );

    always_comb begin
        w_need = '0;
        for (int i = 0; i < DISP_W; i++) begin
            w_need = w_need + CNT_W'(bus.disp_valid[i] & bus.disp_ckpt[i]);
        end
    end

    // Branch events naming a free entry are dropped entirely.
    assign w_free    = (CK_W+1)'(CKPT_N) - r_count;
    assign w_mis     = bus.br_valid &  bus.br_mispred & r_ck[bus.br_id].valid;
    assign w_res     = bus.br_valid & ~bus.br_mispred & r_ck[bus.br_id].valid;
    assign w_grp_ovf = w_need > CNT_W'(w_free);
    assign w_acc     = ~w_mis & ~w_grp_ovf;
    assign w_ovf     = ~w_mis & w_grp_ovf;

    always_comb begin
        w_id_slot   = r_tail;
        bus.ckpt_id = '0;
        for (int i = 0; i < DISP_W; i++) begin
            bus.ckpt_id[i*CK_W +: CK_W] = w_id_slot;
            if (bus.disp_valid[i] && bus.disp_ckpt[i]) begin
                w_id_slot = w_id_slot + CK_W'(1);
            end
        end
    end

    always_comb begin
        w_map   = r_map;
        w_ready = r_ready;
        w_ck    = r_ck;
        w_head  = r_head;
        w_tail  = r_tail;
        w_count = r_count;
        w_slot  = r_tail;
        w_idx   = '0;
        w_off   = '0;
        w_stop  = 1'b0;
        w_ar    = '0;
        w_pr    = '0;

        for (int c = 0; c < CDB_W; c++) begin
            w_ar = bus.cdb_ar[c*AR_W +: AR_W];
            w_pr = bus.cdb_pr[c*PR_W +: PR_W];
            if (bus.cdb_valid[c]) begin
                if (r_map[w_ar] == w_pr) begin
                    w_ready[w_ar] = 1'b1;
                end
                for (int e = 0; e < CKPT_N; e++) begin
                    if (r_ck[e].valid && r_ck[e].map[w_ar] == w_pr) begin
                        w_ck[e].ready[w_ar] = 1'b1;
                    end
                end
            end
        end

        if (w_mis) begin
            // Snapshot ready already carries this cycle's CDB merges.
            w_map   = r_ck[bus.br_id].map;
            w_ready = w_ck[bus.br_id].ready;
            w_tail  = bus.br_id;
            w_count = {1'b0, bus.br_id - r_head};
            for (int e = 0; e < CKPT_N; e++) begin
                w_off = CK_W'(e) - r_head;
                if ({1'b0, w_off} >= w_count) begin
                    w_ck[e].valid = 1'b0;
                    w_ck[e].done  = 1'b0;
                end
            end
        end else begin
            if (w_res) begin
                w_ck[bus.br_id].done = 1'b1;
            end
            for (int k = 0; k < CKPT_N; k++) begin
                w_idx = r_head + CK_W'(k);
                if (!w_stop && w_ck[w_idx].valid && w_ck[w_idx].done) begin
                    w_ck[w_idx].valid = 1'b0;
                    w_ck[w_idx].done  = 1'b0;
                    w_head            = w_idx + CK_W'(1);
                    w_count           = w_count - (CK_W+1)'(1);
                end else begin
                    w_stop = 1'b1;
                end
            end
            if (w_acc) begin
                for (int i = 0; i < DISP_W; i++) begin
                    w_ar = bus.disp_dest[i*AR_W +: AR_W];
                    w_pr = bus.disp_pr[i*PR_W +: PR_W];
                    if (bus.disp_valid[i] && bus.disp_wr[i]) begin
                        w_map[w_ar]   = w_pr;
                        w_ready[w_ar] = 1'b0;
                    end
                    if (bus.disp_valid[i] && bus.disp_ckpt[i]) begin
                        w_ck[w_slot].map   = w_map;
                        w_ck[w_slot].ready = w_ready;
                        w_ck[w_slot].valid = 1'b1;
                        w_ck[w_slot].done  = 1'b0;
                        w_slot             = w_slot + CK_W'(1);
                        w_count            = w_count + (CK_W+1)'(1);
                    end
                end
                w_tail = w_slot;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_AR; r++) begin
                r_map[r] <= PR_W'(r);
            end
            r_ready <= '1;
            for (int e = 0; e < CKPT_N; e++) begin
                r_ck[e] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_map   <= w_map;
            r_ready <= w_ready;
            r_ck    <= w_ck;
            r_head  <= w_head;
            r_tail  <= w_tail;
            r_count <= w_count;
            r_ovf   <= w_ovf;
        end
    end

    assign bus.ckpt_free = w_free;
    assign bus.ckpt_ovf  = r_ovf;

`ifdef MT_PERF_CNT_EN
    logic [31:0]      r_renames, r_restores;
    logic [CNT_W-1:0] w_nren;
    logic [32:0]      w_ren_sum;

    always_comb begin
        w_nren = '0;
        for (int i = 0; i < DISP_W; i++) begin
            w_nren = w_nren + CNT_W'(bus.disp_valid[i] & bus.disp_wr[i]);
        end
    end

    assign w_ren_sum = {1'b0, r_renames} + 33'(w_nren);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_renames  <= '0;
            r_restores <= '0;
        end else begin
            if (w_acc) begin
                r_renames <= w_ren_sum[32] ? '1 : w_ren_sum[31:0];
            end
            if (w_mis && (r_restores != '1)) begin
                r_restores <= r_restores + 32'd1;
            end
        end
    end

    assign renames_cnt  = r_renames;
    assign restores_cnt = r_restores;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mt_ckpt.sv
// +----------------------------------------------------------------------------+
// | tb_mt_ckpt: directed scoreboard bench for mt_ckpt                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mt_ckpt;

    localparam int AR_W = 5;
    localparam int PR_W = 6;
    localparam int CK_W = 2;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    mt_ckpt_if bus ();

`ifdef MT_PERF_CNT_EN
    logic [31:0] renames_cnt, restores_cnt;
`endif

    mt_ckpt dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus)
`ifdef MT_PERF_CNT_EN
        ,
        .renames_cnt  (renames_cnt),
        .restores_cnt (restores_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            $error("FAIL sb_empty observed=%0d expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
        end
    endtask

    task automatic idle();
        bus.disp_valid = '0; bus.disp_wr = '0; bus.disp_ckpt = '0;
        bus.disp_dest = '0; bus.disp_pr = '0; bus.disp_src_a = '0; bus.disp_src_b = '0;
        bus.cdb_valid = '0; bus.cdb_pr = '0; bus.cdb_ar = '0;
        bus.br_valid = 1'b0; bus.br_id = '0; bus.br_mispred = 1'b0;
    endtask

    task automatic lane(input int l, input bit wr, input int dest, input int pr,
                        input int sa, input int sb, input bit ck);
        bus.disp_valid[l]              = 1'b1;
        bus.disp_wr[l]                 = wr;
        bus.disp_ckpt[l]               = ck;
        bus.disp_dest[l*AR_W +: AR_W]  = AR_W'(dest);
        bus.disp_pr[l*PR_W +: PR_W]    = PR_W'(pr);
        bus.disp_src_a[l*AR_W +: AR_W] = AR_W'(sa);
        bus.disp_src_b[l*AR_W +: AR_W] = AR_W'(sb);
    endtask

    task automatic read_src(input int l, input int sa, input int sb);
        bus.disp_src_a[l*AR_W +: AR_W] = AR_W'(sa);
        bus.disp_src_b[l*AR_W +: AR_W] = AR_W'(sb);
    endtask

    task automatic cdb(input int p, input int ar, input int pr);
        bus.cdb_valid[p]             = 1'b1;
        bus.cdb_ar[p*AR_W +: AR_W]   = AR_W'(ar);
        bus.cdb_pr[p*PR_W +: PR_W]   = PR_W'(pr);
    endtask

    task automatic br(input int id, input bit mis);
        bus.br_valid   = 1'b1;
        bus.br_id      = CK_W'(id);
        bus.br_mispred = mis;
    endtask

    task automatic next_cycle();
        @(negedge clock);
        idle();
    endtask

    function automatic logic [31:0] a_pr(input int l);
        return 32'(bus.src_a_pr[l*PR_W +: PR_W]);
    endfunction
    function automatic logic [31:0] b_pr(input int l);
        return 32'(bus.src_b_pr[l*PR_W +: PR_W]);
    endfunction
    function automatic logic [31:0] told(input int l);
        return 32'(bus.told[l*PR_W +: PR_W]);
    endfunction
    function automatic logic [31:0] ck_id(input int l);
        return 32'(bus.ckpt_id[l*CK_W +: CK_W]);
    endfunction

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(negedge clock);
        expect_val("rst_free", 4); expect_val("rst_ovf", 0);
        check(32'(bus.ckpt_free)); check(32'(bus.ckpt_ovf));
        reset = 1'b1;

        read_src(0, 5, 31);
        expect_val("r5_pr", 5); expect_val("r5_rdy", 1);
        expect_val("r31_pr", 31); expect_val("r31_rdy", 1);
        #1;
        check(a_pr(0)); check(32'(bus.src_a_rdy[0])); check(b_pr(0)); check(32'(bus.src_b_rdy[0]));

        // Same-group WAW on r3 with lane1 reading r3
        next_cycle();
        lane(0, 1, 3, 40, 0, 0, 0);
        lane(1, 1, 3, 41, 3, 3, 0);
        expect_val("fwd_src_pr", 40); expect_val("fwd_src_rdy", 0);
        expect_val("fwd_told1", 40); expect_val("fwd_told0", 3);
        #1;
        check(a_pr(1)); check(32'(bus.src_a_rdy[1])); check(told(1)); check(told(0));

        next_cycle();
        read_src(0, 3, 3);
        expect_val("r3_pr", 41); expect_val("r3_rdy", 0);
        #1;
        check(a_pr(0)); check(32'(bus.src_a_rdy[0]));

        cdb(0, 3, 40);
        next_cycle();
        read_src(0, 3, 3);
        expect_val("stale_cdb_rdy", 0);
        #1;
        check(32'(bus.src_a_rdy[0]));

        cdb(0, 3, 41);
        next_cycle();
        read_src(0, 3, 3);
        expect_val("cdb_rdy", 1);
        #1;
        check(32'(bus.src_a_rdy[0]));

        // Dispatch clear beats same-cycle CDB set
        lane(0, 1, 9, 45, 0, 0, 0);
        cdb(1, 9, 9);
        expect_val("told_r9", 9);
        #1;
        check(told(0));
        next_cycle();
        read_src(0, 9, 9);
        expect_val("r9_pr", 45); expect_val("prio_rdy", 0);
        #1;
        check(a_pr(0)); check(32'(bus.src_a_rdy[0]));

        // Fill all four checkpoints, then overflow
        lane(0, 0, 0, 0, 0, 0, 1);
        lane(1, 0, 0, 0, 0, 0, 1);
        expect_val("ckid0", 0); expect_val("ckid1", 1);
        #1;
        check(ck_id(0)); check(ck_id(1));
        next_cycle();
        expect_val("free_2", 2);
        #1;
        check(32'(bus.ckpt_free));
        lane(0, 0, 0, 0, 0, 0, 1);
        lane(1, 0, 0, 0, 0, 0, 1);
        expect_val("ckid2", 2); expect_val("ckid3", 3);
        #1;
        check(ck_id(0)); check(ck_id(1));
        next_cycle();
        expect_val("free_0", 0);
        #1;
        check(32'(bus.ckpt_free));
        lane(0, 1, 4, 60, 0, 0, 1);
        next_cycle();
        read_src(0, 4, 4);
        expect_val("ovf_pulse", 1); expect_val("ovf_free", 0);
        expect_val("ovf_map", 4); expect_val("ovf_rdy", 1);
        #1;
        check(32'(bus.ckpt_ovf)); check(32'(bus.ckpt_free));
        check(a_pr(0)); check(32'(bus.src_a_rdy[0]));
        next_cycle();
        expect_val("ovf_clear", 0);
        #1;
        check(32'(bus.ckpt_ovf));

        // Out-of-order correct resolves
        br(2, 0);
        next_cycle();
        expect_val("res2_free", 0);
        #1;
        check(32'(bus.ckpt_free));
        br(0, 0);
        next_cycle();
        expect_val("res0_free", 1);
        #1;
        check(32'(bus.ckpt_free));
        br(1, 0);
        next_cycle();
        expect_val("res1_free", 3);
        #1;
        check(32'(bus.ckpt_free));
        br(3, 0);
        next_cycle();
        expect_val("res3_free", 4);
        #1;
        check(32'(bus.ckpt_free));

        // Mispredict restore
        lane(0, 0, 0, 0, 0, 0, 1);
        expect_val("ck_a", 0);
        #1;
        check(ck_id(0));
        next_cycle();
        lane(0, 0, 0, 0, 0, 0, 1);
        lane(1, 1, 7, 50, 0, 0, 0);
        expect_val("ck_b", 1);
        #1;
        check(ck_id(0));
        next_cycle();
        read_src(0, 7, 7);
        expect_val("r7_new", 50); expect_val("r7_new_rdy", 0); expect_val("free_mid", 2);
        #1;
        check(a_pr(0)); check(32'(bus.src_a_rdy[0])); check(32'(bus.ckpt_free));
        cdb(0, 7, 7);
        next_cycle();
        read_src(0, 7, 7);
        expect_val("r7_stale_rdy", 0);
        #1;
        check(32'(bus.src_a_rdy[0]));
        br(1, 1);
        lane(0, 1, 7, 55, 0, 0, 0);
        next_cycle();
        read_src(0, 7, 3);
        expect_val("rest_r7", 7); expect_val("rest_r7_rdy", 1);
        expect_val("rest_r3", 41); expect_val("rest_free", 3);
        #1;
        check(a_pr(0)); check(32'(bus.src_a_rdy[0])); check(b_pr(0)); check(32'(bus.ckpt_free));

        // Restore with same-cycle CDB merge
        br(0, 1);
        cdb(2, 9, 45);
        next_cycle();
        read_src(0, 9, 9);
        expect_val("merge_pr", 45); expect_val("merge_rdy", 1); expect_val("merge_free", 4);
        #1;
        check(a_pr(0)); check(32'(bus.src_a_rdy[0])); check(32'(bus.ckpt_free));

        // Branch naming a free entry is ignored; dispatch proceeds
        br(2, 1);
        lane(0, 1, 11, 33, 0, 0, 0);
        next_cycle();
        read_src(0, 11, 7);
        expect_val("ign_free", 4); expect_val("ign_disp", 33); expect_val("ign_r7", 7);
        #1;
        check(32'(bus.ckpt_free)); check(a_pr(0)); check(b_pr(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
